// File: rtl/switch_debounce_pkg.sv
// Board-level constants shared by the switch conditioning path.
// CLK_HZ sets the default debounce window of the top level.
package switch_debounce_pkg;

    localparam int unsigned CLK_HZ     = 10_000_000;
    localparam int unsigned DB_DEFAULT = CLK_HZ / 100;

endpackage

// File: rtl/switch_debounce_bit.sv
// One switch lane: 2-FF synchroniser, stability counter,
// debounced level and registered rise/fall strobes.
module debounce_bit #(
    parameter int unsigned DB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    localparam int unsigned CW = $clog2(DB_CYCLES);
    localparam logic [CW-1:0] CMAX = CW'(DB_CYCLES - 1);

    logic          r_s1;
    logic          r_s2;
    logic [CW-1:0] r_cnt;
    logic          r_db;
    logic          r_rise;
    logic          r_fall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_cnt  <= '0;
            r_db   <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_s1   <= din;
            r_s2   <= r_s1;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            // Any return to the accepted level restarts qualification
            if (r_s2 == r_db) begin
                r_cnt <= '0;
            end else if (r_cnt < CMAX) begin
                r_cnt <= r_cnt + CW'(1);
            end else begin
                r_db   <= r_s2;
                r_cnt  <= '0;
                r_rise <= r_s2;
                r_fall <= ~r_s2;
            end
        end
    end

    assign dout = r_db;
    assign rise = r_rise;
    assign fall = r_fall;

endmodule

// File: rtl/switch_debounce.sv
// Debounced DIP-switch bank: one debounce_bit lane per switch
// plus a bank-wide change strobe.
module switch_debounce
    import switch_debounce_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DB_CYCLES = DB_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_db,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             sw_chg
);

    genvar g;
    generate
        for (g = 0; g < WIDTH; g++) begin : g_bit
            debounce_bit #(
                .DB_CYCLES(DB_CYCLES)
            ) u_bit (
                .clk (clk),
                .rst (rst),
                .din (sw_raw[g]),
                .dout(sw_db[g]),
                .rise(sw_rise[g]),
                .fall(sw_fall[g])
            );
        end
    endgenerate

    // OR of the lane strobe registers, so it lines up with sw_rise/sw_fall
    assign sw_chg = |(sw_rise | sw_fall);

endmodule

// File: tb/tb_switch_debounce.sv
// Randomised and directed checks of switch_debounce against
// a sliding-window reference model.
module tb_switch_debounce;

    localparam int DB = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] sw_raw;
    logic [7:0] sw_db;
    logic [7:0] sw_rise;
    logic [7:0] sw_fall;
    logic       sw_chg;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] m_db;
    logic [7:0] m_rise;
    logic [7:0] m_fall;
    logic       m_chg;
    logic [7:0] q_pipe[$];
    logic [7:0] win[$];

    always #5 clk = ~clk;

    switch_debounce #(
        .WIDTH(8),
        .DB_CYCLES(DB)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .sw_raw (sw_raw),
        .sw_db  (sw_db),
        .sw_rise(sw_rise),
        .sw_fall(sw_fall),
        .sw_chg (sw_chg)
    );

    task automatic model_reset();
        m_db   = 8'h00;
        m_rise = 8'h00;
        m_fall = 8'h00;
        m_chg  = 1'b0;
        q_pipe.delete();
        win.delete();
        q_pipe.push_back(8'h00);
        q_pipe.push_back(8'h00);
    endtask

    // A level is accepted once the last DB synchronised samples
    // all disagree with the currently accepted level.
    task automatic model_edge(input logic [7:0] v);
        logic [7:0] s2v;
        logic       all;
        s2v = q_pipe.pop_front();
        q_pipe.push_back(v);
        win.push_back(s2v);
        if (win.size() > DB) void'(win.pop_front());
        m_rise = 8'h00;
        m_fall = 8'h00;
        for (int b = 0; b < 8; b++) begin
            if (win.size() == DB) begin
                all = 1'b1;
                foreach (win[i]) if (win[i][b] == m_db[b]) all = 1'b0;
                if (all) begin
                    m_db[b] = ~m_db[b];
                    if (m_db[b]) m_rise[b] = 1'b1;
                    else         m_fall[b] = 1'b1;
                end
            end
        end
        m_chg = |(m_rise | m_fall);
    endtask

    task automatic step(input logic [7:0] v);
        sw_raw = v;
        @(posedge clk);
        model_edge(v);
        #1;
    endtask

    task automatic test_reset();
        int acc, nrise, nchg;
        rst    = 1'b1;
        sw_raw = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({sw_db, sw_rise, sw_fall, sw_chg} !== 25'd0) begin
            n_fail++;
            $display("FAIL reset_outs got %h/%h/%h/%b want 0",
                     sw_db, sw_rise, sw_fall, sw_chg);
        end
        rst = 1'b0;
        model_reset();
        acc = 0; nrise = 0; nchg = 0;
        for (int i = 1; i <= 10; i++) begin
            step(8'hFF);
            n_checks++;
            if ({sw_db, sw_rise, sw_fall, sw_chg} !==
                {m_db, m_rise, m_fall, m_chg}) begin
                n_fail++;
                $display("FAIL reset_seq edge %0d got %h/%h/%h/%b want %h/%h/%h/%b",
                         i, sw_db, sw_rise, sw_fall, sw_chg,
                         m_db, m_rise, m_fall, m_chg);
            end
            if (sw_db == 8'hFF && acc == 0) acc = i;
            if (sw_rise == 8'hFF) nrise++;
            if (sw_chg) nchg++;
        end
        n_checks++;
        if (acc !== 6 || nrise !== 1 || nchg !== 1) begin
            n_fail++;
            $display("FAIL reset_requal edge=%0d rise=%0d chg=%0d want 6/1/1",
                     acc, nrise, nchg);
        end
    endtask

    task automatic test_step();
        int acc, nrise, nfall;
        for (int i = 0; i < 10; i++) begin
            step(8'h00);
            n_checks++;
            if ({sw_db, sw_rise, sw_fall, sw_chg} !==
                {m_db, m_rise, m_fall, m_chg}) begin
                n_fail++;
                $display("FAIL clear_seq got %h/%h/%h want %h/%h/%h",
                         sw_db, sw_rise, sw_fall, m_db, m_rise, m_fall);
            end
        end
        acc = 0; nrise = 0; nfall = 0;
        for (int i = 1; i <= 10; i++) begin
            step(8'h01);
            n_checks++;
            if ({sw_db, sw_rise, sw_fall, sw_chg} !==
                {m_db, m_rise, m_fall, m_chg}) begin
                n_fail++;
                $display("FAIL step_seq edge %0d got %h/%h/%h want %h/%h/%h",
                         i, sw_db, sw_rise, sw_fall, m_db, m_rise, m_fall);
            end
            if (sw_db == 8'h01 && acc == 0) acc = i;
            if (sw_rise == 8'h01) nrise++;
            if (sw_fall != 8'h00) nfall++;
        end
        n_checks++;
        if (acc !== 6 || nrise !== 1 || nfall !== 0) begin
            n_fail++;
            $display("FAIL step_latency edge=%0d rise=%0d fall=%0d want 6/1/0",
                     acc, nrise, nfall);
        end
    endtask

    task automatic test_bounce();
        logic [4:0] pat;
        logic       b;
        int         nrise;
        pat   = 5'b10101;
        nrise = 0;
        for (int i = 0; i < 16; i++) begin
            b = (i < 5) ? pat[i] : 1'b1;
            step(8'h01 | {4'h0, b, 3'b000});
            n_checks++;
            if ({sw_db, sw_rise, sw_fall, sw_chg} !==
                {m_db, m_rise, m_fall, m_chg}) begin
                n_fail++;
                $display("FAIL bounce_seq step %0d got %h/%h/%h want %h/%h/%h",
                         i, sw_db, sw_rise, sw_fall, m_db, m_rise, m_fall);
            end
            if (sw_rise[3]) nrise++;
        end
        n_checks++;
        if (nrise !== 1 || sw_db !== 8'h09) begin
            n_fail++;
            $display("FAIL bounce_result rise=%0d db=%h want 1/09", nrise, sw_db);
        end
    endtask

    task automatic test_back_to_back();
        int nfall, nchg;
        for (int i = 0; i < 10; i++) begin
            step(8'h24);
            n_checks++;
            if ({sw_db, sw_rise, sw_fall, sw_chg} !==
                {m_db, m_rise, m_fall, m_chg}) begin
                n_fail++;
                $display("FAIL simul_setup got %h/%h/%h want %h/%h/%h",
                         sw_db, sw_rise, sw_fall, m_db, m_rise, m_fall);
            end
        end
        nfall = 0; nchg = 0;
        for (int i = 0; i < 10; i++) begin
            step(8'h00);
            n_checks++;
            if ({sw_db, sw_rise, sw_fall, sw_chg} !==
                {m_db, m_rise, m_fall, m_chg}) begin
                n_fail++;
                $display("FAIL simul_seq got %h/%h/%h/%b want %h/%h/%h/%b",
                         sw_db, sw_rise, sw_fall, sw_chg,
                         m_db, m_rise, m_fall, m_chg);
            end
            if (sw_fall == 8'h24) nfall++;
            if (sw_chg) nchg++;
        end
        n_checks++;
        if (nfall !== 1 || nchg !== 1) begin
            n_fail++;
            $display("FAIL simul_strobe fall24=%0d chg=%0d want 1/1", nfall, nchg);
        end
    endtask

    task automatic test_glitch();
        for (int i = 0; i < 14; i++) begin
            step((i < 3) ? 8'h01 : 8'h00);
            n_checks++;
            if ({sw_db, sw_rise, sw_fall} !== 24'd0 ||
                {m_db, m_rise, m_fall} !== 24'd0) begin
                n_fail++;
                $display("FAIL glitch step %0d got %h/%h/%h want 00/00/00",
                         i, sw_db, sw_rise, sw_fall);
            end
        end
    endtask

    task automatic test_reset_mid();
        int acc;
        for (int i = 0; i < 4; i++) step(8'h80);
        rst = 1'b1;
        #1;
        n_checks++;
        if ({sw_db, sw_rise, sw_fall, sw_chg} !== 25'd0) begin
            n_fail++;
            $display("FAIL midrst_outs got %h/%h/%h/%b want 0",
                     sw_db, sw_rise, sw_fall, sw_chg);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        acc = 0;
        for (int i = 1; i <= 20 && acc == 0; i++) begin
            step(8'h80);
            n_checks++;
            if ({sw_db, sw_rise, sw_fall, sw_chg} !==
                {m_db, m_rise, m_fall, m_chg}) begin
                n_fail++;
                $display("FAIL midrst_seq edge %0d got %h/%h want %h/%h",
                         i, sw_db, sw_rise, m_db, m_rise);
            end
            if (sw_db[7]) acc = i;
        end
        n_checks++;
        if (acc !== 6) begin
            n_fail++;
            $display("FAIL midrst_latency edge=%0d want 6 (0 = timeout)", acc);
        end
    endtask

    task automatic test_random();
        logic [7:0] r;
        r = sw_raw;
        for (int i = 0; i < 600; i++) begin
            for (int b = 0; b < 8; b++)
                if ($urandom_range(0, 6) == 0) r[b] = ~r[b];
            step(r);
            n_checks++;
            if ({sw_db, sw_rise, sw_fall, sw_chg} !==
                {m_db, m_rise, m_fall, m_chg}) begin
                n_fail++;
                $display("FAIL random step %0d got %h/%h/%h/%b want %h/%h/%h/%b",
                         i, sw_db, sw_rise, sw_fall, sw_chg,
                         m_db, m_rise, m_fall, m_chg);
            end
        end
    endtask

    initial begin
        test_reset();
        test_step();
        test_bounce();
        test_back_to_back();
        test_glitch();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
